instruction_fetch: RTL and testbench

Instruction fetch stage directly upstream of the control unit. It owns the program counter and issues word reads to a synchronous instruction ROM. Returned words are buffered in a small FIFO and presented, already split into OP/Funct3/Funct7 and register/immediate fields, to the decode/control stage over a valid/ready handshake. FLUSH redirects the PC and discards everything in flight.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 40 ++++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, instruction field positions and the fetch FIFO entry type.
// IFETCH_ILLEGAL_CHECK_EN adds a per-entry illegal-opcode bit to the entry.
package fetch_pkg;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;
    localparam int IMM_LSB = 20;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
`ifdef IFETCH_ILLEGAL_CHECK_EN
        logic        illegal;
`endif
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic [AW:0]  count_o,
    output logic         empty_o
);
    fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, credit-limited ROM requests, response buffering and field split.
// IFETCH_ILLEGAL_CHECK_EN adds the ILLEGAL output flagging non-ALU opcodes.
module instruction_fetch import fetch_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              FLUSH,
    input  logic [ADDR_W-1:0] FLUSH_PC,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [31:0]       IMEM_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [6:0]        OP,
    output logic [4:0]        RD,
    output logic [2:0]        Funct3,
    output logic [4:0]        RS1,
    output logic [4:0]        RS2,
    output logic [6:0]        Funct7,
    output logic [11:0]       IMM
`ifdef IFETCH_ILLEGAL_CHECK_EN
    ,
    output logic              ILLEGAL
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q;
    logic inflight_q;
    logic [CW-1:0] count, occ;
    logic empty;
    fetch_entry_t wr_e, head_e;
    logic [31:0] instr;
    logic unused_pc_hi;
    // Credit counts buffered words plus the one response still on its way back.
    assign occ = count + CW'(inflight_q);
    assign IMEM_REQ = RST_N && EN && !FLUSH && (occ < CW'(DEPTH));
    assign IMEM_ADDR = IMEM_REQ ? pc_q : '0;
    assign pc_d = FLUSH ? FLUSH_PC : IMEM_REQ ? pc_q + 1'b1 : pc_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= pc_q;
            inflight_q <= IMEM_REQ;
        end
    end
    always_comb begin
        wr_e       = '0;
        wr_e.instr = IMEM_DATA;
        wr_e.pc    = 32'(req_pc_q);
`ifdef IFETCH_ILLEGAL_CHECK_EN
        wr_e.illegal = !(IMEM_DATA[OP_LSB +: 7] == OP_RTYPE || IMEM_DATA[OP_LSB +: 7] == OP_ITYPE);
`endif
    end
    // A response arriving during FLUSH is the discarded one and never enters the FIFO.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (inflight_q && !FLUSH),
        .pop_i   (OUT_VALID && OUT_READY),
        .flush_i (FLUSH),
        .data_i  (wr_e),
        .data_o  (head_e),
        .count_o (count),
        .empty_o (empty)
    );
    assign OUT_VALID = !empty;
    assign instr  = OUT_VALID ? head_e.instr : '0;
    assign PC_OUT = OUT_VALID ? head_e.pc[ADDR_W-1:0] : '0;
    assign unused_pc_hi = ^head_e.pc;
    assign OP     = instr[OP_LSB +: 7];
    assign RD     = instr[RD_LSB +: 5];
    assign Funct3 = instr[F3_LSB +: 3];
    assign RS1    = instr[RS1_LSB +: 5];
    assign RS2    = instr[RS2_LSB +: 5];
    assign Funct7 = instr[F7_LSB +: 7];
    assign IMM    = instr[IMM_LSB +: 12];
`ifdef IFETCH_ILLEGAL_CHECK_EN
    assign ILLEGAL = OUT_VALID && head_e.illegal;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench with a word-level model of the fetch stream.
module tb_instruction_fetch;
    import fetch_pkg::*;
    localparam int DEPTH = 4;
    localparam logic [7:0] RESET_PC = 8'h00;
    logic CLK = 0, RST_N, EN, FLUSH, OUT_READY, IMEM_REQ, OUT_VALID;
    logic [7:0] FLUSH_PC, IMEM_ADDR, PC_OUT;
    logic [31:0] IMEM_DATA;
    logic [6:0] OP, Funct7;
    logic [4:0] RD, RS1, RS2;
    logic [2:0] Funct3;
    logic [11:0] IMM;
`ifdef IFETCH_ILLEGAL_CHECK_EN
    logic ILLEGAL;
`endif
    instruction_fetch #(.ADDR_W(8), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .PC_OUT(PC_OUT),
        .OP(OP), .RD(RD), .Funct3(Funct3), .RS1(RS1), .RS2(RS2), .Funct7(Funct7), .IMM(IMM)
`ifdef IFETCH_ILLEGAL_CHECK_EN
        , .ILLEGAL(ILLEGAL)
`endif
    );
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic [31:0] rom [256];
    logic [7:0] exp_pc;
    int cyc = 0;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Synchronous ROM: data is only meaningful the cycle after a request.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        IMEM_DATA <= IMEM_REQ ? rom[IMEM_ADDR] : $urandom;
    end

    // Request side: credit = words requested but not yet consumed.
    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("req_in_reset", IMEM_REQ, 0);
            exp_pc = RESET_PC;
        end else begin
            logic exp_req;
            exp_req = EN && !FLUSH && sb.size() < DEPTH;
            chk("req", IMEM_REQ, exp_req);
            if (exp_req) begin
                chk("imem_addr", IMEM_ADDR, exp_pc);
                sb.push_back('{pc: exp_pc, instr: rom[exp_pc], cyc: cyc});
                exp_pc = exp_pc + 8'd1;
            end
            if (FLUSH) exp_pc = FLUSH_PC;
        end
    end

    // Output side: a word becomes visible two cycles after its request.
    always @(negedge CLK) begin
        #1;
        if (!RST_N) begin
            chk("valid_in_reset", OUT_VALID, 0);
            sb.delete();
        end else begin
            logic exp_v;
            exp_v = sb.size() > 0 && sb[0].cyc + 2 <= cyc;
            chk("out_valid", OUT_VALID, exp_v);
            if (exp_v) begin
                chk("pc_out", PC_OUT, sb[0].pc);
                chk("fields", {Funct7, RS2, RS1, Funct3, RD, OP}, sb[0].instr);
                chk("imm", IMM, sb[0].instr[31:20]);
`ifdef IFETCH_ILLEGAL_CHECK_EN
                chk("illegal", ILLEGAL, !(sb[0].instr[6:0] == OP_RTYPE || sb[0].instr[6:0] == OP_ITYPE));
`endif
            end else begin
                chk("idle_outputs", {PC_OUT, OP, IMM}, 0);
            end
            if (FLUSH) sb.delete();
            else if (exp_v && OUT_READY) void'(sb.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_reset();
        RST_N = 0;
        #1;
        chk("valid_drop_on_reset", OUT_VALID, 0);
        chk("req_drop_on_reset", IMEM_REQ, 0);
        step(1);
        RST_N = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (i % 3 != 0) w[6:0] = (i % 2) ? OP_RTYPE : OP_ITYPE;
            rom[i] = w;
        end
        rom[0] = 32'h002081B3;
        rom[1] = 32'h40208233;
        rom[2] = 32'h00508293;
        rom[3] = 32'h0020E333;
        rom[4] = 32'h0000006F;
        rom[5] = NOP;
        RST_N = 0; EN = 0; FLUSH = 0; OUT_READY = 0; FLUSH_PC = '0;
        step(2);
        chk("reset_outputs", {IMEM_REQ, OUT_VALID, IMEM_ADDR, PC_OUT, OP}, 0);
        // Streaming from reset with the consumer always ready.
        RST_N = 1; EN = 1; OUT_READY = 1;
        step(2);
        @(negedge CLK); #2;
        chk("first_valid_cycle2", {OUT_VALID, PC_OUT, OP, Funct3, Funct7}, {1'b1, 8'd0, 7'b0110011, 3'b000, 7'b0000000});
        step(8);
        // Stalled consumer: credits run out after DEPTH requests.
        pulse_reset();
        OUT_READY = 0;
        step(10);
        chk("stall_req_off", IMEM_REQ, 0);
        chk("stall_head", {OUT_VALID, PC_OUT}, {1'b1, 8'h00});
        // Flush with two buffered words and one in flight.
        pulse_reset();
        step(3);
        FLUSH = 1; FLUSH_PC = 8'h40;
        step(1);
        FLUSH = 0; OUT_READY = 1;
        step(2);
        @(negedge CLK); #2;
        chk("flush_head", {OUT_VALID, PC_OUT}, {1'b1, 8'h40});
        step(4);
        // PC wrap.
        FLUSH = 1; FLUSH_PC = 8'hFE;
        step(1);
        FLUSH = 0;
        step(10);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            EN = ($urandom_range(0, 9) != 0);
            OUT_READY = ($urandom_range(0, 2) != 0);
            FLUSH = ($urandom_range(0, 24) == 0);
            FLUSH_PC = ($urandom_range(0, 3) == 0) ? 8'hFD : 8'($urandom);
            if ($urandom_range(0, 150) == 0) pulse_reset();
            else step(1);
        end
        FLUSH = 0; EN = 0; OUT_READY = 1;
        step(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
